// File: rtl/led_step_counter.sv
// LED step counter: heartbeat blink or DIP-stepped up/down count
// with debounced clear, pause/resume and direction buttons.
module led_step_counter #(
  parameter int LED_W     = 8,
  parameter int STEP_W    = 4,
  parameter int PRESC_W   = 25,
  parameter int BLINK_BIT = 23,
  parameter int DB_W      = 16
) (
  input  logic              clk400,
  input  logic              async_reset,
  input  logic [STEP_W-1:0] sw_dip,
  input  logic              btn_clr_n,
  input  logic              btn_pause_n,
  input  logic              btn_dir_n,
  output logic [LED_W-1:0]  led,
  output logic              tick,
  output logic              dir_down,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    BLINK  = 2'b00,
    COUNT  = 2'b01,
    PAUSED = 2'b10
  } st_t;

  localparam int NBTN = 3;

  logic [1:0]        rst_sync;
  logic              rst_n;
  logic [STEP_W-1:0] dip_s1;
  logic [STEP_W-1:0] dip_s2;
  logic [NBTN-1:0]   btn_raw;
  logic [NBTN-1:0]   btn_s1;
  logic [NBTN-1:0]   btn_s2;
  logic [NBTN-1:0]   db_lvl;
  logic [NBTN-1:0]   db_prev;
  logic [NBTN-1:0]   press;
  logic              ev_clr;
  logic              ev_pause;
  logic              ev_dir;
  logic [PRESC_W-1:0] presc;
  logic              dip0;
  logic [LED_W-1:0]  step;
  logic [LED_W-1:0]  blink_val;
  logic [LED_W-1:0]  led_nxt;
  logic              dir_nxt;
  st_t               cur_st;
  st_t               nxt_st;

  // Assert asynchronously, release after two clean clk400 edges.
  always_ff @(posedge clk400 or negedge async_reset) begin
    if (!async_reset) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n = rst_sync[1];

  assign btn_raw = {btn_dir_n, btn_pause_n, btn_clr_n};

  // Two-flop synchronisers for the DIP switches and buttons.
  always_ff @(posedge clk400 or negedge rst_n) begin
    if (!rst_n) begin
      dip_s1 <= '0;
      dip_s2 <= '0;
      btn_s1 <= '1;
      btn_s2 <= '1;
    end else begin
      dip_s1 <= sw_dip;
      dip_s2 <= dip_s1;
      btn_s1 <= btn_raw;
      btn_s2 <= btn_s1;
    end
  end

  for (genvar i = 0; i < NBTN; i++) begin : g_db
    logic [DB_W-1:0] cnt;
    logic            lvl;

    // Counter runs while the sync level disagrees; on saturation
    // the debounced level follows. Any agreement restarts it.
    always_ff @(posedge clk400 or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= '0;
        lvl <= 1'b1;
      end else if (btn_s2[i] == lvl) begin
        cnt <= '0;
      end else if (&cnt) begin
        cnt <= '0;
        lvl <= btn_s2[i];
      end else begin
        cnt <= cnt + DB_W'(1);
      end
    end

    assign db_lvl[i] = lvl;
  end

  // Previous debounced level for 1->0 press edge detection.
  always_ff @(posedge clk400 or negedge rst_n) begin
    if (!rst_n) begin
      db_prev <= '1;
    end else begin
      db_prev <= db_lvl;
    end
  end

  assign press    = db_prev & ~db_lvl;
  assign ev_clr   = press[0];
  assign ev_pause = press[1];
  assign ev_dir   = press[2];

  // Free-running prescaler; a clear event restarts it.
  always_ff @(posedge clk400 or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (ev_clr) begin
      presc <= '0;
    end else begin
      presc <= presc + PRESC_W'(1);
    end
  end

  assign tick = &presc;
  assign dip0 = (dip_s2 == '0);
  assign step = LED_W'(dip_s2);

  // Heartbeat pattern: only the top LED follows the prescaler.
  always_comb begin
    blink_val = '0;
    blink_val[LED_W-1] = presc[BLINK_BIT];
  end

  // Mode state register.
  always_ff @(posedge clk400 or negedge rst_n) begin
    if (!rst_n) begin
      cur_st <= BLINK;
    end else begin
      cur_st <= nxt_st;
    end
  end

  // Mode transitions; DIP is ignored while paused.
  always_comb begin
    nxt_st = cur_st;
    unique case (cur_st)
      BLINK: begin
        if (ev_pause) begin
          nxt_st = PAUSED;
        end else if (!dip0) begin
          nxt_st = COUNT;
        end
      end
      COUNT: begin
        if (ev_pause) begin
          nxt_st = PAUSED;
        end else if (dip0) begin
          nxt_st = BLINK;
        end
      end
      PAUSED: begin
        if (ev_pause) begin
          nxt_st = dip0 ? BLINK : COUNT;
        end
      end
      default: nxt_st = BLINK;
    endcase
  end

  // LED and direction next values; clear overrides everything.
  always_comb begin
    led_nxt = led;
    dir_nxt = dir_down;
    if (ev_clr) begin
      led_nxt = '1;
      dir_nxt = 1'b0;
    end else begin
      if (ev_dir) begin
        dir_nxt = ~dir_down;
      end
      if (cur_st == BLINK) begin
        led_nxt = blink_val;
      end else if (cur_st == COUNT && tick) begin
        led_nxt = dir_down ? led - step : led + step;
      end
    end
  end

  // LED and direction registers.
  always_ff @(posedge clk400 or negedge rst_n) begin
    if (!rst_n) begin
      led      <= '1;
      dir_down <= 1'b0;
    end else begin
      led      <= led_nxt;
      dir_down <= dir_nxt;
    end
  end

  assign state = cur_st;

endmodule

// File: tb/tb_led_step_counter.sv
// Scoreboard bench for led_step_counter with a small prescaler
// and debouncer so every mode is reached in a few thousand cycles.
module tb_led_step_counter;

  logic       clk400 = 1'b0;
  logic       async_reset = 1'b0;
  logic [3:0] sw_dip = 4'h0;
  logic       btn_clr_n = 1'b1;
  logic       btn_pause_n = 1'b1;
  logic       btn_dir_n = 1'b1;
  logic [7:0] led;
  logic       tick;
  logic       dir_down;
  logic [1:0] state;

  always #5 clk400 = ~clk400;

  led_step_counter #(
    .LED_W(8), .STEP_W(4), .PRESC_W(4),
    .BLINK_BIT(3), .DB_W(2)
  ) dut (
    .clk400(clk400),
    .async_reset(async_reset),
    .sw_dip(sw_dip),
    .btn_clr_n(btn_clr_n),
    .btn_pause_n(btn_pause_n),
    .btn_dir_n(btn_dir_n),
    .led(led),
    .tick(tick),
    .dir_down(dir_down),
    .state(state)
  );

  typedef struct {
    string      name;
    logic [3:0] mask;
    logic [7:0] led;
    logic [1:0] st;
    logic       dir;
    logic       tk;
    logic       to;
  } probe_t;

  probe_t     pq[$];
  logic [7:0] tq[$];
  int         checks = 0;
  int         errors = 0;
  logic       armed = 1'b0;
  probe_t     mp;
  logic [7:0] me;
  logic       bad;
  logic [7:0] v;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk400);
    #1;
  endtask

  // mask: [3] led, [2] state, [1] dir_down, [0] tick
  task automatic probe(input string nm, input logic [3:0] m,
                       input logic [7:0] l, input logic [1:0] s,
                       input logic d, input logic t);
    probe_t p;
    p.name = nm; p.mask = m; p.led = l;
    p.st = s; p.dir = d; p.tk = t; p.to = 1'b0;
    pq.push_back(p);
  endtask

  task automatic timeout(input string nm);
    probe_t p;
    p.name = nm; p.mask = 4'h0; p.led = 8'h00;
    p.st = 2'b00; p.dir = 1'b0; p.tk = 1'b0; p.to = 1'b1;
    pq.push_back(p);
  endtask

  task automatic wait_tick(input string nm);
    int   n;
    logic got;
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk400);
      if (tick) got = 1'b1;
      n++;
    end
    if (!got) timeout(nm);
    @(posedge clk400);
    #1;
  endtask

  task automatic wait_empty(input string nm, input int budget);
    int n;
    n = 0;
    while (tq.size() != 0 && n < budget) begin
      cyc(1);
      n++;
    end
    if (tq.size() != 0) begin
      timeout(nm);
      tq.delete();
    end
  endtask

  // which: [0] clear, [1] pause, [2] dir; returns as the action lands
  task automatic push_btn(input logic [2:0] which);
    btn_clr_n   = !which[0];
    btn_pause_n = !which[1];
    btn_dir_n   = !which[2];
    cyc(7);
  endtask

  task automatic rel_btn();
    cyc(3);
    btn_clr_n   = 1'b1;
    btn_pause_n = 1'b1;
    btn_dir_n   = 1'b1;
    cyc(8);
  endtask

  // Monitor: drains probes, and checks led on the cycle after a tick.
  initial begin
    forever begin
      @(negedge clk400);
      while (pq.size() > 0) begin
        mp = pq.pop_front();
        checks++;
        bad = mp.to
           || (mp.mask[3] && led !== mp.led)
           || (mp.mask[2] && state !== mp.st)
           || (mp.mask[1] && dir_down !== mp.dir)
           || (mp.mask[0] && tick !== mp.tk);
        if (bad) begin
          errors++;
          if (mp.to)
            $display("FAIL %s: timed out waiting for DUT event", mp.name);
          else
            $display("FAIL %s: got led=%h st=%b dir=%b tick=%b, want led=%h st=%b dir=%b tick=%b (mask %b)",
                     mp.name, led, state, dir_down, tick,
                     mp.led, mp.st, mp.dir, mp.tk, mp.mask);
        end
      end
      if (armed && tq.size() > 0) begin
        me = tq.pop_front();
        checks++;
        if (led !== me) begin
          errors++;
          $display("FAIL tick_led: got led=%h want %h", led, me);
        end
      end
      armed = tick;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1 reset values and first tick after release
    cyc(3);
    probe("rst_hold", 4'b1111, 8'hFF, 2'b00, 1'b0, 1'b0);
    async_reset = 1'b1;
    cyc(16);
    probe("pre_tick", 4'b0101, 8'h00, 2'b00, 1'b0, 1'b0);
    cyc(1);
    probe("first_tick", 4'b1101, 8'h80, 2'b00, 1'b0, 1'b1);

    // 2 heartbeat blink: 8 cycles per phase, tick every 16
    cyc(1);
    probe("blink_p0", 4'b1101, 8'h80, 2'b00, 1'b0, 1'b0);
    cyc(1);
    probe("blink_p1", 4'b1001, 8'h00, 2'b00, 1'b0, 1'b0);
    cyc(7);
    probe("blink_p8", 4'b1001, 8'h00, 2'b00, 1'b0, 1'b0);
    cyc(1);
    probe("blink_p9", 4'b1001, 8'h80, 2'b00, 1'b0, 1'b0);
    cyc(6);
    probe("blink_p15", 4'b1001, 8'h80, 2'b00, 1'b0, 1'b1);

    // 3 count up by 3 from FF with wrap
    sw_dip = 4'h3;
    cyc(4);
    probe("to_count", 4'b0110, 8'h00, 2'b01, 1'b0, 1'b0);
    wait_tick("tick_t3");
    push_btn(3'b001);
    probe("clear_t3", 4'b1110, 8'hFF, 2'b01, 1'b0, 1'b0);
    v = 8'hFF;
    for (int k = 0; k < 86; k++) begin
      v = v + 8'h03;
      tq.push_back(v);
    end
    rel_btn();
    wait_empty("count_up", 1500);

    // 4 direction toggle at 05
    wait_tick("tick_t4");
    push_btn(3'b001);
    probe("clear_t4", 4'b1110, 8'hFF, 2'b01, 1'b0, 1'b0);
    tq.push_back(8'h02);
    tq.push_back(8'h05);
    rel_btn();
    wait_empty("to_05", 60);
    push_btn(3'b100);
    probe("dir_set", 4'b1110, 8'h05, 2'b01, 1'b1, 1'b0);
    tq.push_back(8'h02);
    tq.push_back(8'hFF);
    tq.push_back(8'hFC);
    rel_btn();
    wait_empty("count_dn", 80);

    // 5 glitch rejected, then pause / resume
    tq.push_back(8'hF9);
    btn_pause_n = 1'b0;
    cyc(3);
    btn_pause_n = 1'b1;
    cyc(6);
    probe("glitch", 4'b0110, 8'h00, 2'b01, 1'b1, 1'b0);
    wait_empty("to_F9", 40);
    push_btn(3'b010);
    probe("paused", 4'b1110, 8'hF9, 2'b10, 1'b1, 1'b0);
    tq.push_back(8'hF9);
    tq.push_back(8'hF9);
    tq.push_back(8'hF9);
    rel_btn();
    wait_empty("frozen", 80);
    push_btn(3'b010);
    probe("resumed", 4'b1110, 8'hF9, 2'b01, 1'b1, 1'b0);
    tq.push_back(8'hF6);
    rel_btn();
    wait_empty("resume_F6", 40);

    // 6 clear and dir together: clear wins
    wait_tick("tick_t6");
    push_btn(3'b101);
    probe("clr_dir", 4'b1110, 8'hFF, 2'b01, 1'b0, 1'b0);
    tq.push_back(8'h02);
    rel_btn();
    wait_empty("after_clr", 40);

    // reset asserted mid-count takes effect immediately
    cyc(5);
    async_reset = 1'b0;
    #1;
    probe("rst_mid", 4'b1111, 8'hFF, 2'b00, 1'b0, 1'b0);
    cyc(3);
    probe("rst_mid_hold", 4'b1111, 8'hFF, 2'b00, 1'b0, 1'b0);
    async_reset = 1'b1;
    cyc(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
